// File: rtl/alu_cmd_driver.sv
// Sequences one host command at a time into an attached alu_top and returns its result.
// Latency: LATENCY+1 cycles from accept to rsp_valid for legal ops, immediate RESP for /0 or %0.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
module alu_cmd_driver #(
  parameter int N       = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_op1,
  input  logic [N-1:0]     cmd_op2,
  input  logic [3:0]       cmd_sel,
  output logic [N-1:0]     alu_operand1,
  output logic [N-1:0]     alu_operand2,
  output logic [3:0]       alu_select,
  input  logic [2*N-1:0]   alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_result,
  output logic [3:0]       rsp_sel,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      op_count
);

  // Wait counter is 4 bits wide, enough for LATENCY 0..15.
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N-1:0]     op1_q, op1_d;
  logic [N-1:0]     op2_q, op2_d;
  logic [3:0]       sel_q, sel_d;
  logic [2*N-1:0]   res_q, res_d;
  logic [3:0]       rsel_q, rsel_d;
  logic             err_q, err_d;
  logic [15:0]      ops_q, ops_d;
  logic             cmd_illegal;

  // Divide and modulo by zero are never sent to the ALU.
  assign cmd_illegal = ((cmd_sel == 4'd3) || (cmd_sel == 4'd4)) && (cmd_op2 == '0);

  // Next-state and datapath decisions for the three-state sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    res_d   = res_q;
    rsel_d  = rsel_q;
    err_d   = err_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rsel_d = cmd_sel;
          if (cmd_illegal) begin
            // ALU outputs keep the previous command; error response goes out directly.
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            op1_d   = cmd_op1;
            op2_d   = cmd_op2;
            sel_d   = cmd_sel;
            cnt_d   = LAT_CNT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Return to IDLE only; a new command waits for the next cycle.
        if (rsp_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over any handshake in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      rsel_q  <= '0;
      err_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      rsel_q  <= rsel_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_select   = sel_q;
  assign rsp_result   = res_q;
  assign rsp_sel      = rsel_q;
  assign rsp_err      = err_q;
  assign op_count     = ops_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver with a one-cycle ALU model and a response scoreboard.
// Latency: checked per command against LATENCY+1 edges (legal) or immediate (illegal).
// Backpressure: rsp_ready held low for a number of cycles on selected commands.
module tb_alu_cmd_driver;

  localparam int N   = 4;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [N-1:0]   cmd_op1;
  logic [N-1:0]   cmd_op2;
  logic [3:0]     cmd_sel;
  logic [N-1:0]   alu_operand1;
  logic [N-1:0]   alu_operand2;
  logic [3:0]     alu_select;
  logic [2*N-1:0] alu_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*N-1:0] rsp_result;
  logic [3:0]     rsp_sel;
  logic           rsp_err;
  logic           busy;
  logic [15:0]    op_count;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [3:0]  exp_a, exp_b, exp_s;
  logic [15:0] exp_count;

  always #5 clk = ~clk;

  alu_cmd_driver #(.N(N), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op1      (cmd_op1),
    .cmd_op2      (cmd_op2),
    .cmd_sel      (cmd_sel),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_select   (alu_select),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_sel      (rsp_sel),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .op_count     (op_count)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [7:0] ea, eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (s)
      4'd0:    return ea + eb;
      4'd1:    return ea - eb;
      4'd2:    return ea * eb;
      4'd3:    return (b != 0) ? ea % eb : 8'd0;
      4'd4:    return (b != 0) ? ea / eb : 8'd0;
      4'd5:    return ea & eb;
      4'd6:    return ea | eb;
      4'd7:    return ea ^ eb;
      default: return {a, b};
    endcase
  endfunction

  // One-cycle ALU model feeding the driver.
  always @(posedge clk) alu_result <= alu_f(alu_operand1, alu_operand2, alu_select);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop and compare on every response handshake, sampled mid-cycle after inputs settle.
  always begin
    @(negedge clk);
    #2;
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        check_eq("rsp_sel",    32'(rsp_sel),    32'(mon_e.sel));
        check_eq("rsp_err",    32'(rsp_err),    32'(mon_e.err));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready),    32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid),    32'd0);
    check_eq({tag, "_busy"},      32'(busy),         32'd0);
    check_eq({tag, "_rsp_err"},   32'(rsp_err),      32'd0);
    check_eq({tag, "_rsp_res"},   32'(rsp_result),   32'd0);
    check_eq({tag, "_rsp_sel"},   32'(rsp_sel),      32'd0);
    check_eq({tag, "_alu_op1"},   32'(alu_operand1), 32'd0);
    check_eq({tag, "_alu_op2"},   32'(alu_operand2), 32'd0);
    check_eq({tag, "_alu_sel"},   32'(alu_select),   32'd0);
    check_eq({tag, "_op_count"},  32'(op_count),     32'd0);
  endtask

  // Issue one command from a negedge, follow it to its response handshake.
  task automatic do_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s, input int hold);
    bit   illegal;
    int   lat;
    int   t;
    exp_t e;
    illegal = ((s == 4'd3) || (s == 4'd4)) && (b == 4'd0);
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op1   = a;
    cmd_op2   = b;
    cmd_sel   = s;
    rsp_ready = (hold == 0);
    e.sel = s;
    e.res = illegal ? 8'd0 : alu_f(a, b, s);
    e.err = illegal;
    exp_q.push_back(e);
    if (!illegal) begin
      exp_a = a;
      exp_b = b;
      exp_s = s;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold > 0) begin
      // A different command stays pending while the response is outstanding.
      cmd_op1 = ~a;
      cmd_op2 = 4'd1;
      cmd_sel = 4'd5;
    end else begin
      cmd_valid = 1'b0;
    end
    check_eq("accept_busy",  32'(busy),         32'd1);
    check_eq("accept_ready", 32'(cmd_ready),    32'd0);
    check_eq("alu_operand1", 32'(alu_operand1), 32'(exp_a));
    check_eq("alu_operand2", 32'(alu_operand2), 32'(exp_b));
    check_eq("alu_select",   32'(alu_select),   32'(exp_s));
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("latency", 32'(lat), illegal ? 32'd0 : 32'(LAT + 1));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_rsp_valid", 32'(rsp_valid),  32'd1);
      check_eq("bp_rsp_res",   32'(rsp_result), 32'(e.res));
      check_eq("bp_rsp_sel",   32'(rsp_sel),    32'(e.sel));
      check_eq("bp_cmd_ready", 32'(cmd_ready),  32'd0);
      check_eq("bp_alu_sel",   32'(alu_select), 32'(exp_s));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check_eq("op_count",      32'(op_count),   32'(exp_count));
    check_eq("post_rsp_vld",  32'(rsp_valid),  32'd0);
    check_eq("post_rsp_rdy",  32'(cmd_ready),  32'd1);
    check_eq("post_alu_sel",  32'(alu_select), 32'(exp_s));
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  // Accept a legal command, then assert reset while it sits in WAIT.
  task automatic reset_in_wait();
    cmd_valid = 1'b1;
    cmd_op1   = 4'd3;
    cmd_op2   = 4'd3;
    cmd_sel   = 4'd0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_wait");
    exp_a     = '0;
    exp_b     = '0;
    exp_s     = '0;
    exp_count = '0;
  endtask

  initial begin
    int seen;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op1   = '0;
    cmd_op2   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    exp_a     = '0;
    exp_b     = '0;
    exp_s     = '0;
    exp_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;

    do_cmd(4'd2,  4'd1,  4'd0, 0);
    do_cmd(4'd12, 4'd10, 4'd2, 0);
    do_cmd(4'd7,  4'd0,  4'd3, 0);
    do_cmd(4'd9,  4'd0,  4'd4, 0);
    do_cmd(4'd9,  4'd4,  4'd1, 5);
    do_cmd(4'd13, 4'd4,  4'd3, 0);
    do_cmd(4'd13, 4'd4,  4'd4, 2);
    do_cmd(4'd5,  4'd3,  4'd7, 0);
    do_cmd(4'd15, 4'd15, 4'd2, 0);
    do_cmd(4'd6,  4'd9,  4'd11, 0);

    // Reset during WAIT, then a command on the very first edge after release.
    reset_in_wait();
    reset = 1'b0;
    do_cmd(4'd6, 4'd2, 4'd4, 0);

    // Reset during WAIT, then idle: the discarded command must never answer.
    reset_in_wait();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    seen      = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    check_eq("no_rsp_after_rst", 32'(seen), 32'd0);
    check_eq("idle_op_count",    32'(op_count), 32'd0);

    // Start the counter just below rollover.
    force dut.ops_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.ops_q;
    exp_count = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    check_eq("preload_count", 32'(op_count), 32'hFFFE);
    do_cmd(4'd1, 4'd1, 4'd0, 0);
    do_cmd(4'd4, 4'd3, 4'd2, 0);
    do_cmd(4'd8, 4'd2, 4'd4, 0);
    check_eq("wrap_count", 32'(op_count), 32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
